wb_stage: RTL
=============

// Module: wb_stage
// PURPOSE
//  Write-back stage of the 5-stage RV32I pipeline, directly downstream of the memory-access stage.
//  - Selects the load result or the ALU result from MA.
//  - Aligns and extends the load result.
//  - Owns the 32x32 integer register file (two async read ports for ID).
//  - Drives two forwarding taps toward ID/EX: current WB and a one-cycle-delayed WB2.
// PARAMETERS
//  NREG    32     number of architectural registers (index 0 hard-wired to zero)
//  XLEN    32     data width
// PORTS
//  clk           in   1   system clock
//  rst           in   1   asynchronous reset, active-high
//  cmd_ld_wb     in   1   instruction in WB is a load
//  ld_code_wb    in   3   funct3 of load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//  rd_adr_wb     in   5   destination register index
//  rd_data_wb    in   32  ALU result / effective address (bits [1:0] = load byte offset)
//  wbk_rd_reg_wb in   1   instruction writes rd
//  ld_data_wb    in   32  raw 32-bit word returned by data RAM / IO (already stall-held by MA)
//  stall         in   1   pipeline stall; WB holds, no commit this cycle
//  rst_pipe      in   1   pipeline flush
//  rs1_adr_id    in   5   ID read port 1 index
//  rs2_adr_id    in   5   ID read port 2 index
//  rs1_data_id   out  32  ID read port 1 data (combinational)
//  rs2_data_id   out  32  ID read port 2 data (combinational)
//  wbk_en_wb     out  1   commit strobe: wbk_rd_reg_wb & ~stall & (rd_adr_wb != 0)
//  wbk_adr_wb    out  5   = rd_adr_wb
//  wbk_data_wb   out  32  final write-back value (forwarding tap 1, combinational)
//  wbk_en_wb2    out  1   registered copy of wbk_en_wb (forwarding tap 2)
//  wbk_adr_wb2   out  5   registered copy of wbk_adr_wb
//  wbk_data_wb2  out  32  registered copy of wbk_data_wb
// BEHAVIOUR
//  - Byte offset: ofs = rd_data_wb[1:0].
//  - Load extract:
//    - LB/LBU take byte ofs; LH/LHU take half ofs[1]; LW takes the full word.
//    - LB/LH sign-extend; LBU/LHU zero-extend.
//    - Codes 011/110/111 give 32'd0.
//  - wbk_data_wb = cmd_ld_wb ? extracted load : rd_data_wb.
//  - Regfile write:
//    - Occurs at posedge clk when wbk_en_wb = 1 (1-cycle latency to array).
//    - Writes to x0 are dropped; x0 always reads 0.
//  - stall=1: no write; the same instruction commits exactly once on the first cycle with stall=0.
//  - rst_pipe: does not block the WB commit (the WB instruction is older than any flush cause).
//    Clears wbk_en_wb2/adr/data to 0 at the next edge.
//  - WB2 regs load wbk_* every cycle with stall=0.
//    During stall, wbk_en_wb2 is cleared to 0 and adr/data hold.
//    A stalled commit is therefore never forwarded twice.
//  - Precedence at a clock edge: rst > rst_pipe > stall.
//  - Reset (rst=1, async): all 31 registers = 0; wbk_en_wb2=0, wbk_adr_wb2=0, wbk_data_wb2=0.
//    Combinational outputs follow their inputs.
//  - Reads are combinational from the array; both ports may address the same register.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//    rsN_data_id = wbk_data_wb when wbk_en_wb & (rsN_adr_id == wbk_adr_wb).
//    Same-cycle write-through, so ID needs no WB-distance forwarding.
//  REGFILE_BYPASS_EN undefined:
//    rsN_data_id returns the pre-write array value.
//    ID/EX must use the wbk_*_wb taps for that hazard.
// TESTING
//  - LB, ld_data=32'h80FF7F01, ofs=3, rd=5, wbk=1 -> wbk_data=32'hFFFFFF80; x5=32'hFFFFFF80 next cycle.
//  - LHU ld_data=32'h8001_1234, ofs=2 -> 32'h00008001; LH same -> 32'hFFFF8001; code 011 -> 0.
//  - ALU op rd_data=32'h12345678, rd=0, wbk=1 -> wbk_en_wb=0; rs1_adr_id=0 reads 0.
//  - rd=7, stall=1 for 3 cycles then 0 -> x7 written once, on the release edge.
//    wbk_en_wb2=0 during stall, then 1 for exactly one cycle.
//  - Write x9=32'hCAFEF00D with rs1_adr_id=9 same cycle.
//    With REGFILE_BYPASS_EN: rs1_data_id=32'hCAFEF00D that cycle; without it: old value.
//  - rst pulsed mid-run after writing x1..x31 -> all read 0; WB2 taps 0; rst_pipe clears only WB2.

Source files
------------

// File: rtl/wb_stage_if.sv
// wb_stage_if: MA->WB inputs, ID read ports and WB forwarding taps.
// master drives the stage inputs; slave is the wb_stage side.
interface wb_stage_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            cmd_ld_wb;
  logic [2:0]      ld_code_wb;
  logic [AW-1:0]   rd_adr_wb;
  logic [XLEN-1:0] rd_data_wb;
  logic            wbk_rd_reg_wb;
  logic [XLEN-1:0] ld_data_wb;
  logic            stall;
  logic            rst_pipe;
  logic [AW-1:0]   rs1_adr_id;
  logic [AW-1:0]   rs2_adr_id;
  logic [XLEN-1:0] rs1_data_id;
  logic [XLEN-1:0] rs2_data_id;
  logic            wbk_en_wb;
  logic [AW-1:0]   wbk_adr_wb;
  logic [XLEN-1:0] wbk_data_wb;
  logic            wbk_en_wb2;
  logic [AW-1:0]   wbk_adr_wb2;
  logic [XLEN-1:0] wbk_data_wb2;

  modport master (
    output cmd_ld_wb, ld_code_wb, rd_adr_wb, rd_data_wb,
    output wbk_rd_reg_wb, ld_data_wb, stall, rst_pipe,
    output rs1_adr_id, rs2_adr_id,
    input  rs1_data_id, rs2_data_id,
    input  wbk_en_wb, wbk_adr_wb, wbk_data_wb,
    input  wbk_en_wb2, wbk_adr_wb2, wbk_data_wb2
  );

  modport slave (
    input  cmd_ld_wb, ld_code_wb, rd_adr_wb, rd_data_wb,
    input  wbk_rd_reg_wb, ld_data_wb, stall, rst_pipe,
    input  rs1_adr_id, rs2_adr_id,
    output rs1_data_id, rs2_data_id,
    output wbk_en_wb, wbk_adr_wb, wbk_data_wb,
    output wbk_en_wb2, wbk_adr_wb2, wbk_data_wb2
  );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: RV32I write-back, load align/extend, regfile, WB/WB2 taps.
// Optional REGFILE_BYPASS_EN: same-cycle write-through on ID reads.
module wb_stage #(
  parameter int NREG = 32,
  parameter int XLEN = 32
) (
  input  logic      clk,
  input  logic      rst,
  wb_stage_if.slave wb
);
  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] rf [NREG];
  logic [1:0]      ofs;
  logic [7:0]      ld_b;
  logic [15:0]     ld_h;
  logic [XLEN-1:0] ld_ext;
  logic [XLEN-1:0] wbk_data;
  logic            wbk_en;
  logic            en2_q;
  logic [AW-1:0]   adr2_q;
  logic [XLEN-1:0] data2_q;

  // Load byte/half select and sign/zero extension
  always_comb begin
    ofs    = wb.rd_data_wb[1:0];
    ld_b   = wb.ld_data_wb[7:0];
    ld_h   = ofs[1] ? wb.ld_data_wb[31:16]
                    : wb.ld_data_wb[15:0];
    ld_ext = '0;
    unique case (ofs)
      2'd0: ld_b = wb.ld_data_wb[7:0];
      2'd1: ld_b = wb.ld_data_wb[15:8];
      2'd2: ld_b = wb.ld_data_wb[23:16];
      2'd3: ld_b = wb.ld_data_wb[31:24];
      default: ld_b = wb.ld_data_wb[7:0];
    endcase
    unique case (wb.ld_code_wb)
      3'b000: ld_ext = {{(XLEN-8){ld_b[7]}}, ld_b};
      3'b001: ld_ext = {{(XLEN-16){ld_h[15]}}, ld_h};
      3'b010: ld_ext = wb.ld_data_wb;
      3'b100: ld_ext = {{(XLEN-8){1'b0}}, ld_b};
      3'b101: ld_ext = {{(XLEN-16){1'b0}}, ld_h};
      default: ld_ext = '0;
    endcase
  end

  assign wbk_data = wb.cmd_ld_wb ? ld_ext : wb.rd_data_wb;
  assign wbk_en   = wb.wbk_rd_reg_wb & ~wb.stall
                  & (wb.rd_adr_wb != '0);

  assign wb.wbk_en_wb   = wbk_en;
  assign wb.wbk_adr_wb  = wb.rd_adr_wb;
  assign wb.wbk_data_wb = wbk_data;

  // Register file array; x0 is never written so it stays zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wbk_en) begin
      rf[wb.rd_adr_wb] <= wbk_data;
    end
  end

  // ID read ports, optional same-cycle write-through
`ifdef REGFILE_BYPASS_EN
  assign wb.rs1_data_id =
    (wb.rs1_adr_id == '0) ? '0 :
    (wbk_en && wb.rs1_adr_id == wb.rd_adr_wb) ? wbk_data :
    rf[wb.rs1_adr_id];
  assign wb.rs2_data_id =
    (wb.rs2_adr_id == '0) ? '0 :
    (wbk_en && wb.rs2_adr_id == wb.rd_adr_wb) ? wbk_data :
    rf[wb.rs2_adr_id];
`else
  assign wb.rs1_data_id =
    (wb.rs1_adr_id == '0) ? '0 : rf[wb.rs1_adr_id];
  assign wb.rs2_data_id =
    (wb.rs2_adr_id == '0) ? '0 : rf[wb.rs2_adr_id];
`endif

  // WB2 tap: flush clears, stall drops the strobe, else follow WB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en2_q   <= 1'b0;
      adr2_q  <= '0;
      data2_q <= '0;
    end else if (wb.rst_pipe) begin
      en2_q   <= 1'b0;
      adr2_q  <= '0;
      data2_q <= '0;
    end else if (wb.stall) begin
      en2_q   <= 1'b0;
    end else begin
      en2_q   <= wbk_en;
      adr2_q  <= wb.rd_adr_wb;
      data2_q <= wbk_data;
    end
  end

  assign wb.wbk_en_wb2   = en2_q;
  assign wb.wbk_adr_wb2  = adr2_q;
  assign wb.wbk_data_wb2 = data2_q;
endmodule
